// File: rtl/lsu_mem_master.sv
// Load/store initiator for the single-port word memory.
// One request at a time. Loads are aligned and extended. Sub-word stores
// are done as a read-modify-write, because the memory is word-wide only.
//
// state | meaning
// IDLE  | ready for a request; latches it on req_valid
// RD    | mem_ren asserted; read data sampled at the closing edge
// WR    | mem_wen asserted; memory commits at the mid-cycle negedge
// RESP  | resp_valid pulse, then back to IDLE
module lsu_mem_master (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_ren_q, mem_ren_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic        misaligned;

    // Lane extraction, extension and store merge from the current read word.
    always_comb begin
        byte_lane = mem_dout[{addr_lo_q, 3'b000} +: 8];
        half_lane = mem_dout[{addr_lo_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_ext = signed_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
            2'b01:   load_ext = signed_q ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
            default: load_ext = mem_dout;
        endcase
        merged = mem_dout;
        if (size_q == 2'b00)
            merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        misaligned = (req_size == 2'b01 && req_addr[0]) ||
                     (req_size[1] && req_addr[1:0] != 2'b00);
    end

    // Next-state and next-output decode; memory enables last exactly one state.
    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        signed_d     = signed_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_ren_d    = 1'b0;
        mem_wen_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_lo_d  = req_addr[1:0];
                    size_d     = req_size;
                    signed_d   = req_signed;
                    write_d    = req_write;
                    wdata_d    = req_wdata;
                    mem_addr_d = {2'b00, req_addr[31:2]};
                    if (misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (req_write && req_size[1]) begin
                        state_d   = WR;
                        mem_wen_d = 1'b1;
                        mem_din_d = req_wdata;
                    end else begin
                        state_d   = RD;
                        mem_ren_d = 1'b1;
                    end
                end
            end
            RD: begin
                if (write_q) begin
                    state_d   = WR;
                    mem_wen_d = 1'b1;
                    mem_din_d = merged;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_ext;
                    resp_err_d   = 1'b0;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_lo_q    <= 2'b00;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_ren_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_din_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_ren_q    <= mem_ren_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_ren    = mem_ren_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small word-memory model.
module tb_lsu_mem_master;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:15];
    logic        preload_req = 1'b0;
    logic        overlap_seen = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    lsu_mem_master dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    // memory model: write commits at the negedge inside the WR cycle
    always @(negedge clock) begin
        if (preload_req) mem[4] <= 32'h8899AABB;
        else if (mem_wen) mem[mem_addr[3:0]] <= mem_din;
    end
    assign mem_dout = (mem_ren && !mem_wen) ? mem[mem_addr[3:0]] : 32'h0;

    always @(negedge clock) if (mem_ren && mem_wen) overlap_seen <= 1'b1;

    // drive one request; returns #1 after the accepting posedge (cycle k+1)
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        vectors++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hold ren=%b wen=%b valid=%b req 0/0/0", mem_ren, mem_wen, resp_valid); end
        @(negedge clock); preload_req = 1'b1;
        @(negedge clock); preload_req = 1'b0; reset = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b req 1", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b req 0", resp_valid); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h req 0", resp_rdata); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b req 0", resp_err); end
        vectors++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin miscompares++; $display("FAIL reset_en ren=%b wen=%b req 0/0", mem_ren, mem_wen); end
        vectors++; if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin miscompares++; $display("FAIL reset_addr_din addr=%h din=%h req 0/0", mem_addr, mem_din); end
    endtask

    task automatic test_lw();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        vectors++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0) begin miscompares++; $display("FAIL lw_k1_en ren=%b wen=%b req 1/0", mem_ren, mem_wen); end
        vectors++; if (mem_addr !== 32'd4) begin miscompares++; $display("FAIL lw_k1_addr got %h req 4", mem_addr); end
        vectors++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL lw_k1_busy ready=%b valid=%b req 0/0", req_ready, resp_valid); end
        step();
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL lw_k2_valid got %b req 1", resp_valid); end
        vectors++; if (resp_rdata !== 32'h8899AABB || resp_err !== 1'b0) begin miscompares++; $display("FAIL lw_k2_data got %h err %b req 8899aabb err 0", resp_rdata, resp_err); end
        vectors++; if (mem_ren !== 1'b0) begin miscompares++; $display("FAIL lw_k2_ren got %b req 0", mem_ren); end
        step();
        vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL lw_k3_idle valid=%b ready=%b req 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_subword_loads();
        logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exp [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sz[i], sg[i], ad[i], 32'h0);
            step();
            vectors++; if (resp_valid !== 1'b1 || resp_rdata !== exp[i] || resp_err !== 1'b0) begin miscompares++; $display("FAIL load_%0d valid=%b data=%h err=%b req 1 %h 0", i, resp_valid, resp_rdata, resp_err, exp[i]); end
            step();
        end
    endtask

    task automatic test_sb_rmw();
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456CC);
        vectors++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL sb_rd ren=%b wen=%b valid=%b req 1/0/0", mem_ren, mem_wen, resp_valid); end
        step();
        vectors++; if (mem_ren !== 1'b0 || mem_wen !== 1'b1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL sb_wr ren=%b wen=%b valid=%b req 0/1/0", mem_ren, mem_wen, resp_valid); end
        vectors++; if (mem_din !== 32'h8899CCBB || mem_addr !== 32'd4) begin miscompares++; $display("FAIL sb_wr_din din=%h addr=%h req 8899ccbb 4", mem_din, mem_addr); end
        step();
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin miscompares++; $display("FAIL sb_resp valid=%b data=%h err=%b req 1 0 0", resp_valid, resp_rdata, resp_err); end
        step();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        step();
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h8899CCBB) begin miscompares++; $display("FAIL sb_readback valid=%b data=%h req 1 8899ccbb", resp_valid, resp_rdata); end
        step();
    endtask

    task automatic test_sw();
        issue(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
        vectors++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_din !== 32'hDEADBEEF || mem_addr !== 32'd5) begin miscompares++; $display("FAIL sw_wr wen=%b ren=%b din=%h addr=%h req 1 0 deadbeef 5", mem_wen, mem_ren, mem_din, mem_addr); end
        step();
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL sw_resp got %b req 1", resp_valid); end
        step();
        issue(1'b0, 2'b11, 1'b0, 32'h14, 32'h0);
        step();
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_readback valid=%b data=%h req 1 deadbeef", resp_valid, resp_rdata); end
        step();
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [2] = '{2'b10, 2'b01};
        logic        wr [2] = '{1'b0, 1'b1};
        logic [31:0] ad [2] = '{32'h12, 32'h11};
        for (int i = 0; i < 2; i++) begin
            issue(wr[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF);
            vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin miscompares++; $display("FAIL misal_%0d valid=%b err=%b data=%h req 1 1 0", i, resp_valid, resp_err, resp_rdata); end
            vectors++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin miscompares++; $display("FAIL misal_%0d_en ren=%b wen=%b req 0/0", i, mem_ren, mem_wen); end
            step();
            vectors++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL misal_%0d_after ren=%b wen=%b valid=%b ready=%b req 0 0 0 1", i, mem_ren, mem_wen, resp_valid, req_ready); end
        end
    endtask

    task automatic test_reset_mid();
        logic got_valid;
        got_valid = 1'b0;
        issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h00005555);
        vectors++; if (mem_ren !== 1'b1) begin miscompares++; $display("FAIL rstmid_rd ren=%b req 1", mem_ren); end
        reset = 1'b0;
        #1;
        vectors++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL rstmid_async ren=%b wen=%b ready=%b addr=%h req 0 0 1 0", mem_ren, mem_wen, req_ready, mem_addr); end
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (resp_valid !== 1'b0 || mem_wen !== 1'b0) got_valid = 1'b1;
        end
        vectors++; if (got_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_noresp saw valid/wen after reset req none"); end
        vectors++; if (mem[4] !== 32'h8899CCBB) begin miscompares++; $display("FAIL rstmid_mem got %h req 8899ccbb", mem[4]); end
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        step();
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h8899CCBB || resp_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_lw valid=%b data=%h err=%b req 1 8899ccbb 0", resp_valid, resp_rdata, resp_err); end
        step();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_subword_loads();
        test_sb_rmw();
        test_sw();
        test_misaligned();
        test_reset_mid();
        vectors++; if (overlap_seen !== 1'b0) begin miscompares++; $display("FAIL ren_wen_overlap got 1 req 0"); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator for the single-port word memory: accepts one load or store request at a time from the datapath and drives the memory's ren/wen/addr/din protocol. It captures read data and returns aligned, sign- or zero-extended load results. Byte and halfword stores are done as a read-modify-write, because the memory is word-wide only. It sits between the MEM stage and the memory block.

## Interface
- No parameters; data and address widths are fixed at 32.
- clock  in  1  system clock; state updates on posedge.
- reset  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned request; valid with resp_valid.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  32  word index, equal to {2'b00, addr[31:2]}.
- mem_din  out  32  memory write data.
- mem_dout  in  32  memory read data; combinational while ren=1 and wen=0.

## Operation
- **States:** IDLE, RD, WR, RESP. All outputs except req_ready are registered. req_ready = (state == IDLE).
- **IDLE:** when req_valid is high, latch addr, size, signed, write and wdata. Next state:
  - RESP with err=1 if misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - RD for any load.
  - WR for a word store, with mem_din = wdata.
  - RD for a byte or half store (read-modify-write).
- **RD:** mem_ren=1, mem_wen=0. mem_dout is sampled at the closing posedge.
  - Load: extract the lane, extend it, go to RESP.
  - Sub-word store: merge the store data into the read word, go to WR.
- **WR:** mem_wen=1, mem_ren=0, mem_din = merged or full word. The memory commits at the negedge inside this cycle. Next state is RESP.
- **RESP:** resp_valid=1, then IDLE. resp_rdata/resp_err hold until the next RESP; resp_valid is the only qualifier.
- **Lanes (little-endian):**
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
  - Store merge replaces only the addressed lane with the low 8 or 16 bits of wdata.
- **Invariant:** mem_ren and mem_wen are never both 1. In RMW the RD→WR transition drops ren and raises wen on the same posedge.
- **Address range:** address bits above the memory range are passed through unchanged. This is not an error.
- **Busy:** requests arriving while not in IDLE are ignored; the requester must hold req_valid.

## Timing
- **Acceptance:** a request is accepted at posedge k when req_valid & req_ready.
- **Latency from acceptance to resp_valid:**
  - Misaligned: asserted in cycle k+1.
  - Load and word store: cycle k+2.
  - Sub-word store: cycle k+3.
- **Throughput:** after RESP a new request is accepted at the earliest one cycle later (IDLE). Peak is one load per 3 cycles.
- **Reset values:** state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_din=0.
- **Reset mid-operation:** asserting reset forces all outputs to the reset values immediately, asynchronously.
  - The in-flight request is dropped and no response is issued.
  - If reset asserts in WR before the negedge, no write occurs.

## Test plan
- Hold reset low 3 cycles, release, preload memory word 4 = 0x8899AABB -> all outputs at reset values and req_ready=1.
- lw addr 0x10 -> mem_ren=1 with mem_addr=4 in cycle k+1; resp_valid in cycle k+2 with resp_rdata=0x8899AABB, resp_err=0.
- lb signed addr 0x13 -> 0xFFFFFF88; lbu addr 0x13 -> 0x00000088; lh signed addr 0x12 -> 0xFFFF8899; lhu addr 0x10 -> 0x0000AABB.
- sb addr 0x11, wdata 0x123456CC:
  - Expect RD, then WR with mem_din=0x8899CCBB, then resp_valid in cycle k+3.
  - A following lw 0x10 returns 0x8899CCBB.
  - The ren&wen overlap check must never fire.
- Misaligned requests: lw addr 0x12 and sh addr 0x11 -> resp_valid in cycle k+1 with resp_err=1, resp_rdata=0, and no ren/wen pulse.
- Reset during RD of sh addr 0x10 -> ren drops immediately, no resp_valid, memory word 4 unchanged. A subsequent lw 0x10 completes normally.
